// File: rtl/riscv_mem_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// riscv_mem_arbiter_pkg
// Shared types for the unified-memory arbiter: FSM state encoding, requester
// identifiers, counter width and a saturating increment helper.
// No ports (package).
// -----------------------------------------------------------------------------
package riscv_mem_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY_IF = 2'd1,
        BUSY_DM = 2'd2
    } arb_state_t;

    typedef enum logic {
        REQ_IF = 1'b0,
        REQ_DM = 1'b1
    } req_id_t;

    // Width of the latency counter and of the data-grant streak counter.
    localparam int CNT_W = 4;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v,
                                                 input logic [CNT_W-1:0] lim);
        return (v >= lim) ? lim : v + CNT_W'(1);
    endfunction

endpackage

// File: rtl/riscv_mem_arbiter_if.sv
// -----------------------------------------------------------------------------
// riscv_mem_arbiter_if
// Bundles the three buses around the arbiter:
//   fetch port  : if_req, if_addr -> if_rdata, if_valid, stall_if
//   data port   : dm_req, dm_we, dm_addr, dm_wdata -> dm_rdata, dm_done, stall_mem
//   memory port : mem_en, mem_we, mem_addr, mem_wdata <- mem_rdata
// Modport slave is the arbiter's view; master is the view of the pipeline plus
// memory that surround it.
// -----------------------------------------------------------------------------
interface riscv_mem_arbiter_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
);
    logic                  if_req;
    logic [ADDR_WIDTH-1:0] if_addr;
    logic [DATA_WIDTH-1:0] if_rdata;
    logic                  if_valid;
    logic                  dm_req;
    logic                  dm_we;
    logic [ADDR_WIDTH-1:0] dm_addr;
    logic [DATA_WIDTH-1:0] dm_wdata;
    logic [DATA_WIDTH-1:0] dm_rdata;
    logic                  dm_done;
    logic                  mem_en;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [DATA_WIDTH-1:0] mem_rdata;
    logic                  stall_if;
    logic                  stall_mem;

    modport slave (
        input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
        output if_rdata, if_valid, dm_rdata, dm_done,
               mem_en, mem_we, mem_addr, mem_wdata, stall_if, stall_mem
    );

    modport master (
        output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
        input  if_rdata, if_valid, dm_rdata, dm_done,
               mem_en, mem_we, mem_addr, mem_wdata, stall_if, stall_mem
    );
endinterface

// File: rtl/riscv_mem_arbiter_grant.sv
// -----------------------------------------------------------------------------
// riscv_mem_arbiter_grant
// Priority decision between fetch and data requesters plus the data-grant
// streak counter that prevents fetch starvation.
// Ports:
//   clk, reset       clock, asynchronous active-low reset
//   i_if_req         fetch request pending
//   i_dm_req         data request pending
//   i_grant_en       arbiter is able to issue this cycle
//   o_grant_if       fetch wins this cycle
//   o_grant_dm       data wins this cycle
// -----------------------------------------------------------------------------
module riscv_mem_arbiter_grant
    import riscv_mem_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic i_if_req,
    input  logic i_dm_req,
    input  logic i_grant_en,
    output logic o_grant_if,
    output logic o_grant_dm
);

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    logic [CNT_W-1:0] r_dm_streak;
    logic             w_if_wins;

    // Data normally wins; a pending fetch takes over once data has won
    // STARVE_LIMIT times in a row against it.
    assign w_if_wins  = i_if_req & (~i_dm_req | (r_dm_streak == LIMIT));
    assign o_grant_if = i_grant_en & w_if_wins;
    assign o_grant_dm = i_grant_en & i_dm_req & ~w_if_wins;

    // The streak only grows when a fetch was actually waiting and lost.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_dm_streak <= '0;
        end else if (o_grant_if) begin
            r_dm_streak <= '0;
        end else if (o_grant_dm && i_if_req) begin
            r_dm_streak <= sat_inc(r_dm_streak, LIMIT);
        end
    end

endmodule

// File: rtl/riscv_mem_arbiter.sv
// -----------------------------------------------------------------------------
// riscv_mem_arbiter
// Shares one single-port memory between instruction fetch and data access.
// One access is in flight at a time; the grant is combinational in IDLE, the
// response is returned MEM_LATENCY cycles after issue with read data passed
// straight through from the memory.
// Ports:
//   clk      clock, all state on posedge
//   reset    asynchronous active-low reset
//   io_bus   riscv_mem_arbiter_if.slave: fetch, data and memory ports, stalls
// -----------------------------------------------------------------------------
module riscv_mem_arbiter
    import riscv_mem_arbiter_pkg::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 32,
    parameter int MEM_LATENCY  = 1,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                clk,
    input  logic                reset,
    riscv_mem_arbiter_if.slave  io_bus
);

    localparam logic [CNT_W-1:0] LAT = CNT_W'(MEM_LATENCY);

    arb_state_t            r_state;
    arb_state_t            w_next_state;
    logic [CNT_W-1:0]      r_lat_cnt;
    logic [CNT_W-1:0]      w_lat_cnt_next;
    logic [ADDR_WIDTH-1:0] r_mem_addr;
    logic [DATA_WIDTH-1:0] r_mem_wdata;
    logic                  w_grant_en;
    logic                  w_grant_if;
    logic                  w_grant_dm;
    logic                  w_done;
    req_id_t               w_winner;

    // Gating with reset keeps mem_en low while reset is held even though the
    // grant itself is combinational on the request lines.
    assign w_grant_en = (r_state == IDLE) & reset;
    assign w_winner   = w_grant_dm ? REQ_DM : REQ_IF;
    assign w_done     = (r_state != IDLE) && (r_lat_cnt == LAT);

    riscv_mem_arbiter_grant #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_grant (
        .clk        (clk),
        .reset      (reset),
        .i_if_req   (io_bus.if_req),
        .i_dm_req   (io_bus.dm_req),
        .i_grant_en (w_grant_en),
        .o_grant_if (w_grant_if),
        .o_grant_dm (w_grant_dm)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= IDLE;
            r_lat_cnt   <= '0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
        end else begin
            r_state   <= w_next_state;
            r_lat_cnt <= w_lat_cnt_next;
            // Latch the issued address/data so the memory port holds them
            // for the rest of the access.
            if (w_grant_dm) begin
                r_mem_addr  <= io_bus.dm_addr;
                r_mem_wdata <= io_bus.dm_wdata;
            end else if (w_grant_if) begin
                r_mem_addr  <= io_bus.if_addr;
            end
        end
    end

    always_comb begin
        w_next_state     = r_state;
        w_lat_cnt_next   = r_lat_cnt;
        io_bus.mem_en    = 1'b0;
        io_bus.mem_we    = 1'b0;
        io_bus.mem_addr  = r_mem_addr;
        io_bus.mem_wdata = r_mem_wdata;
        io_bus.if_valid  = 1'b0;
        io_bus.if_rdata  = '0;
        io_bus.dm_done   = 1'b0;
        io_bus.dm_rdata  = '0;

        case (r_state)
            IDLE: begin
                if (w_grant_if || w_grant_dm) begin
                    io_bus.mem_en  = 1'b1;
                    w_lat_cnt_next = CNT_W'(1);
                    if (w_winner == REQ_DM) begin
                        io_bus.mem_we    = io_bus.dm_we;
                        io_bus.mem_addr  = io_bus.dm_addr;
                        io_bus.mem_wdata = io_bus.dm_wdata;
                        w_next_state     = BUSY_DM;
                    end else begin
                        io_bus.mem_addr  = io_bus.if_addr;
                        w_next_state     = BUSY_IF;
                    end
                end
            end
            BUSY_IF: begin
                if (w_done) begin
                    io_bus.if_valid = 1'b1;
                    io_bus.if_rdata = io_bus.mem_rdata;
                    w_next_state    = IDLE;
                    w_lat_cnt_next  = '0;
                end else begin
                    w_lat_cnt_next  = r_lat_cnt + CNT_W'(1);
                end
            end
            BUSY_DM: begin
                if (w_done) begin
                    io_bus.dm_done  = 1'b1;
                    io_bus.dm_rdata = io_bus.mem_rdata;
                    w_next_state    = IDLE;
                    w_lat_cnt_next  = '0;
                end else begin
                    w_lat_cnt_next  = r_lat_cnt + CNT_W'(1);
                end
            end
            default: begin
                w_next_state   = IDLE;
                w_lat_cnt_next = '0;
            end
        endcase
    end

    assign io_bus.stall_if  = io_bus.if_req & ~io_bus.if_valid;
    assign io_bus.stall_mem = io_bus.dm_req & ~io_bus.dm_done;

endmodule

// File: tb/tb_riscv_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_riscv_mem_arbiter
// Three arbiters with MEM_LATENCY 1, 2 and 3 share one clock and reset; each
// has its own memory model. Stimulus pushes expected issues and responses into
// queues; a monitor pops and compares whenever a DUT presents mem_en or a
// completion pulse.
// -----------------------------------------------------------------------------
module tb_riscv_mem_arbiter;

    localparam int DW = 32;
    localparam int AW = 32;
    localparam int NI = 3;

    typedef struct {
        int              inst;
        logic            we;
        logic [AW-1:0]   addr;
        logic [DW-1:0]   wdata;
    } iss_t;

    typedef struct {
        int              inst;
        logic            is_dm;
        logic            chk_data;
        logic [DW-1:0]   data;
    } rsp_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    logic          s_if_req   [NI];
    logic [AW-1:0] s_if_addr  [NI];
    logic          s_dm_req   [NI];
    logic          s_dm_we    [NI];
    logic [AW-1:0] s_dm_addr  [NI];
    logic [DW-1:0] s_dm_wdata [NI];

    logic          o_if_valid  [NI];
    logic [DW-1:0] o_if_rdata  [NI];
    logic          o_dm_done   [NI];
    logic [DW-1:0] o_dm_rdata  [NI];
    logic          o_mem_en    [NI];
    logic          o_mem_we    [NI];
    logic [AW-1:0] o_mem_addr  [NI];
    logic [DW-1:0] o_mem_wdata [NI];
    logic          o_stall_if  [NI];
    logic          o_stall_mem [NI];

    iss_t q_iss[$];
    rsp_t q_rsp[$];
    int   en_cnt [NI];
    int   n_checks = 0;
    int   n_fail   = 0;

    function automatic logic [DW-1:0] pattern(input logic [AW-1:0] a);
        return (a == 32'h10) ? 32'h0050_0093 : {16'hC0DE, a[15:0]};
    endfunction

    for (genvar g = 0; g < NI; g++) begin : g_inst
        riscv_mem_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) u_bus ();

        logic [DW-1:0] mdat  [64];
        logic          mwr   [64];
        logic [DW-1:0] rpipe [g+1];
        logic [5:0]    idx;

        assign u_bus.if_req   = s_if_req[g];
        assign u_bus.if_addr  = s_if_addr[g];
        assign u_bus.dm_req   = s_dm_req[g];
        assign u_bus.dm_we    = s_dm_we[g];
        assign u_bus.dm_addr  = s_dm_addr[g];
        assign u_bus.dm_wdata = s_dm_wdata[g];
        assign u_bus.mem_rdata = rpipe[g];

        assign o_if_valid[g]  = u_bus.if_valid;
        assign o_if_rdata[g]  = u_bus.if_rdata;
        assign o_dm_done[g]   = u_bus.dm_done;
        assign o_dm_rdata[g]  = u_bus.dm_rdata;
        assign o_mem_en[g]    = u_bus.mem_en;
        assign o_mem_we[g]    = u_bus.mem_we;
        assign o_mem_addr[g]  = u_bus.mem_addr;
        assign o_mem_wdata[g] = u_bus.mem_wdata;
        assign o_stall_if[g]  = u_bus.stall_if;
        assign o_stall_mem[g] = u_bus.stall_mem;

        assign idx = u_bus.mem_addr[7:2];

        // Memory model: reads appear g+1 cycles after the issue cycle.
        always @(posedge clk or negedge reset) begin
            if (!reset) begin
                for (int k = 0; k < 64; k++) mwr[k] <= 1'b0;
            end else if (u_bus.mem_en && u_bus.mem_we) begin
                mdat[idx] <= u_bus.mem_wdata;
                mwr[idx]  <= 1'b1;
            end
        end

        always @(posedge clk) begin
            rpipe[0] <= (u_bus.mem_en && !u_bus.mem_we) ?
                        (mwr[idx] ? mdat[idx] : pattern(u_bus.mem_addr)) : '0;
            for (int k = 1; k < g + 1; k++) rpipe[k] <= rpipe[k-1];
        end

        riscv_mem_arbiter #(
            .DATA_WIDTH   (DW),
            .ADDR_WIDTH   (AW),
            .MEM_LATENCY  (g + 1),
            .STARVE_LIMIT (4)
        ) u_dut (
            .clk    (clk),
            .reset  (reset),
            .io_bus (u_bus.slave)
        );
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic exp_iss(input int g, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        iss_t e;
        e.inst = g; e.we = we; e.addr = a; e.wdata = d;
        q_iss.push_back(e);
    endtask

    task automatic exp_rsp(input int g, input logic is_dm, input logic chk, input logic [DW-1:0] d);
        rsp_t e;
        e.inst = g; e.is_dm = is_dm; e.chk_data = chk; e.data = d;
        q_rsp.push_back(e);
    endtask

    // mode 0: fetch valid, 1: data done, 2: either
    task automatic wait_rsp(input int g, input int mode, input int lim, output int n);
        logic hit;
        n = 0;
        hit = 1'b0;
        while (!hit && n < lim) begin
            @(negedge clk);
            n++;
            hit = (mode == 0) ? o_if_valid[g] :
                  (mode == 1) ? o_dm_done[g]  : (o_if_valid[g] | o_dm_done[g]);
        end
        if (!hit) begin
            n_checks++;
            n_fail++;
            $display("FAIL rsp_timeout inst=%0d actual=none required=response within %0d cycles", g, lim);
        end
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        iss_t ei;
        rsp_t er;
        for (int g = 0; g < NI; g++) begin
            if (o_mem_en[g]) begin
                en_cnt[g]++;
                if (q_iss.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL iss_unexpected inst=%0d actual=mem_en=1 addr=%h required=no issue", g, o_mem_addr[g]);
                end else begin
                    ei = q_iss.pop_front();
                    check("iss_inst", g, ei.inst);
                    check("iss_we", {31'd0, o_mem_we[g]}, {31'd0, ei.we});
                    check("iss_addr", o_mem_addr[g], ei.addr);
                    if (ei.we) check("iss_wdata", o_mem_wdata[g], ei.wdata);
                end
            end
            if (o_if_valid[g] || o_dm_done[g]) begin
                check("rsp_one_hot", {31'd0, o_if_valid[g] & o_dm_done[g]}, 32'd0);
                if (q_rsp.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL rsp_unexpected inst=%0d actual=if_valid=%0b dm_done=%0b required=no response",
                             g, o_if_valid[g], o_dm_done[g]);
                end else begin
                    er = q_rsp.pop_front();
                    check("rsp_inst", g, er.inst);
                    check("rsp_kind", {31'd0, o_dm_done[g]}, {31'd0, er.is_dm});
                    if (er.chk_data)
                        check("rsp_data", o_dm_done[g] ? o_dm_rdata[g] : o_if_rdata[g], er.data);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        int first_if;
        int en_before;
        for (int g = 0; g < NI; g++) begin
            s_if_req[g] = 1'b0; s_if_addr[g] = '0; s_dm_req[g] = 1'b0;
            s_dm_we[g] = 1'b0; s_dm_addr[g] = '0; s_dm_wdata[g] = '0;
            en_cnt[g] = 0;
        end

        // Reset state
        repeat (2) @(negedge clk);
        for (int g = 0; g < NI; g++) begin
            check("rst_mem_en",   {31'd0, o_mem_en[g]}, 32'd0);
            check("rst_valid",    {30'd0, o_if_valid[g], o_dm_done[g]}, 32'd0);
            check("rst_mem_addr", o_mem_addr[g], 32'd0);
            check("rst_rdata",    o_if_rdata[g] | o_dm_rdata[g], 32'd0);
        end
        tick();
        reset = 1'b1;
        tick();

        // Test 1: single fetch, latency 1
        exp_iss(0, 1'b0, 32'h10, 32'h0);
        exp_rsp(0, 1'b0, 1'b1, 32'h0050_0093);
        s_if_req[0] = 1'b1; s_if_addr[0] = 32'h10;
        @(negedge clk);
        check("t1_mem_en_T",  {31'd0, o_mem_en[0]}, 32'd1);
        check("t1_stall_T",   {31'd0, o_stall_if[0]}, 32'd1);
        check("t1_mem_addr",  o_mem_addr[0], 32'h10);
        tick();
        @(negedge clk);
        check("t1_valid_T1",  {31'd0, o_if_valid[0]}, 32'd1);
        check("t1_rdata_T1",  o_if_rdata[0], 32'h0050_0093);
        check("t1_stall_T1",  {31'd0, o_stall_if[0]}, 32'd0);
        check("t1_mem_en_T1", {31'd0, o_mem_en[0]}, 32'd0);
        tick();
        s_if_req[0] = 1'b0;
        @(negedge clk);
        check("t1_idle_en", {31'd0, o_mem_en[0]}, 32'd0);

        // Test 2: store then back-to-back load at 0x40
        tick();
        exp_iss(0, 1'b1, 32'h40, 32'hDEAD_BEEF);
        exp_rsp(0, 1'b1, 1'b0, 32'h0);
        s_dm_req[0] = 1'b1; s_dm_we[0] = 1'b1; s_dm_addr[0] = 32'h40; s_dm_wdata[0] = 32'hDEAD_BEEF;
        @(negedge clk);
        check("t2_mem_we",    {31'd0, o_mem_we[0]}, 32'd1);
        check("t2_stall_mem", {31'd0, o_stall_mem[0]}, 32'd1);
        tick();
        @(negedge clk);
        check("t2_done_T1",   {31'd0, o_dm_done[0]}, 32'd1);
        check("t2_hold_addr", o_mem_addr[0], 32'h40);
        check("t2_hold_wdata", o_mem_wdata[0], 32'hDEAD_BEEF);
        check("t2_busy_en",   {31'd0, o_mem_en[0]}, 32'd0);
        tick();
        exp_iss(0, 1'b0, 32'h40, 32'h0);
        exp_rsp(0, 1'b1, 1'b1, 32'hDEAD_BEEF);
        s_dm_we[0] = 1'b0;
        wait_rsp(0, 1, 10, n);
        check("t2_load_lat", n, 2);
        tick();
        s_dm_req[0] = 1'b0;

        // Test 3: both held; fetch must win on the fifth round
        for (int r = 0; r < 4; r++) begin
            exp_iss(0, 1'b0, 32'h200, 32'h0);
            exp_rsp(0, 1'b1, 1'b1, 32'hC0DE_0200);
        end
        exp_iss(0, 1'b0, 32'h100, 32'h0);
        exp_rsp(0, 1'b0, 1'b1, 32'hC0DE_0100);
        exp_iss(0, 1'b0, 32'h200, 32'h0);
        exp_rsp(0, 1'b1, 1'b1, 32'hC0DE_0200);
        tick();
        s_if_req[0] = 1'b1; s_if_addr[0] = 32'h100;
        s_dm_req[0] = 1'b1; s_dm_we[0] = 1'b0; s_dm_addr[0] = 32'h200;
        first_if = 0;
        for (int r = 1; r <= 6; r++) begin
            wait_rsp(0, 2, 10, n);
            check("t3_round_len", n, 2);
            if (o_if_valid[0] && first_if == 0) first_if = r;
        end
        check("t3_first_if_round", first_if, 5);
        tick();
        s_if_req[0] = 1'b0; s_dm_req[0] = 1'b0;

        // Test 4: latency 3 fetch, re-issue no earlier than T+4
        tick();
        en_before = en_cnt[2];
        exp_iss(2, 1'b0, 32'h20, 32'h0);
        exp_rsp(2, 1'b0, 1'b1, 32'hC0DE_0020);
        exp_iss(2, 1'b0, 32'h20, 32'h0);
        exp_rsp(2, 1'b0, 1'b1, 32'hC0DE_0020);
        s_if_req[2] = 1'b1; s_if_addr[2] = 32'h20;
        wait_rsp(2, 0, 10, n);
        check("t4_lat", n, 4);
        check("t4_en_pulses", en_cnt[2] - en_before, 1);
        tick();
        @(negedge clk);
        check("t4_reissue_T4", {31'd0, o_mem_en[2]}, 32'd1);
        tick();
        s_if_req[2] = 1'b0;
        wait_rsp(2, 0, 10, n);
        check("t4_dropped_lat", n, 3);
        tick();

        // Test 6: data request dropped mid-access, latency 2
        exp_iss(1, 1'b0, 32'h44, 32'h0);
        exp_rsp(1, 1'b1, 1'b1, 32'hC0DE_0044);
        s_dm_req[1] = 1'b1; s_dm_we[1] = 1'b0; s_dm_addr[1] = 32'h44;
        tick();
        s_dm_req[1] = 1'b0;
        wait_rsp(1, 1, 10, n);
        check("t6_done_T2", n, 2);
        tick();
        exp_iss(1, 1'b0, 32'h80, 32'h0);
        exp_rsp(1, 1'b0, 1'b1, 32'hC0DE_0080);
        s_if_req[1] = 1'b1; s_if_addr[1] = 32'h80;
        wait_rsp(1, 0, 10, n);
        check("t6_idle_then_fetch", n, 3);
        tick();
        s_if_req[1] = 1'b0;

        // Test 5: reset in the middle of a latency-3 load
        tick();
        exp_iss(2, 1'b0, 32'h80, 32'h0);
        s_dm_req[2] = 1'b1; s_dm_we[2] = 1'b0; s_dm_addr[2] = 32'h80;
        @(negedge clk);
        tick();
        reset = 1'b0;
        s_dm_req[2] = 1'b0;
        #1;
        check("t5_rst_mem_en",  {31'd0, o_mem_en[2]}, 32'd0);
        check("t5_rst_mem_we",  {31'd0, o_mem_we[2]}, 32'd0);
        check("t5_rst_flags",   {28'd0, o_if_valid[2], o_dm_done[2], o_stall_if[2], o_stall_mem[2]}, 32'd0);
        check("t5_rst_addr",    o_mem_addr[2], 32'd0);
        check("t5_rst_wdata",   o_mem_wdata[2], 32'd0);
        check("t5_rst_rdata",   o_if_rdata[2] | o_dm_rdata[2], 32'd0);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check("t5_no_done", {31'd0, o_dm_done[2]}, 32'd0);
        end
        s_dm_req[2] = 1'b1;
        #1;
        check("t5_en_in_reset", {31'd0, o_mem_en[2]}, 32'd0);
        check("t5_stall_follow", {31'd0, o_stall_mem[2]}, 32'd1);
        exp_iss(2, 1'b0, 32'h80, 32'h0);
        exp_rsp(2, 1'b1, 1'b1, 32'hC0DE_0080);
        tick();
        reset = 1'b1;
        wait_rsp(2, 1, 10, n);
        check("t5_fresh_lat", n, 4);
        tick();
        s_dm_req[2] = 1'b0;

        repeat (4) tick();
        check("sb_iss_empty", q_iss.size(), 0);
        check("sb_rsp_empty", q_rsp.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
